// File: rtl/l3_cache_pkg.sv
// Shared types and address-split helpers for the burst L3 cache.
package l3_cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WB     = 3'd1,
        ST_FILL   = 3'd2,
        ST_RESP_R = 3'd3,
        ST_RESP_B = 3'd4
    } state_t;

    // Tag storage is sized for the widest possible tag; only the low TAG_W bits are used.
    localparam int TAG_MAX = 32;

    typedef struct packed {
        logic               valid;
        logic               dirty;
        logic [TAG_MAX-1:0] tag;
    } line_meta_t;

    function automatic int calc_offset_bits(input int line_words);
        return (line_words > 1) ? $clog2(line_words) : 0;
    endfunction

    function automatic int calc_set_bits(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int calc_tag_bits(input int addr_width, input int num_sets, input int line_words);
        return addr_width - calc_set_bits(num_sets) - calc_offset_bits(line_words);
    endfunction

    // A zero-width field still needs a one-bit carrier register.
    function automatic int calc_field_width(input int bits);
        return (bits > 0) ? bits : 1;
    endfunction

endpackage

// File: rtl/l3_lru_ctrl.sv
// True-age LRU bookkeeping: per-set age permutation, victim pick and access update.
module l3_lru_ctrl
    import l3_cache_pkg::*;
#(
    parameter int NUM_SETS = 256,
    parameter int ASSOC    = 4,
    localparam int SET_W   = $clog2(NUM_SETS),
    localparam int WAY_W   = $clog2(ASSOC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SET_W-1:0] lookup_set,
    input  logic [ASSOC-1:0] invalid_vec,
    output logic [WAY_W-1:0] victim_way,
    input  logic             upd_en,
    input  logic [SET_W-1:0] upd_set,
    input  logic [WAY_W-1:0] upd_way
);

    logic [WAY_W-1:0] age_r [NUM_SETS][ASSOC];
    logic [WAY_W-1:0] inv_pick_s;
    logic [WAY_W-1:0] age_pick_s;
    logic [WAY_W-1:0] old_age_s;

    assign old_age_s = age_r[upd_set][upd_way];

    // Victim: lowest-index invalid way first, otherwise the oldest way of the set.
    always_comb begin
        inv_pick_s = '0;
        age_pick_s = '0;
        for (int w = ASSOC - 1; w >= 0; w--) begin
            inv_pick_s = invalid_vec[w] ? WAY_W'(w) : inv_pick_s;
        end
        for (int w = 0; w < ASSOC; w++) begin
            age_pick_s = (age_r[lookup_set][w] == WAY_W'(ASSOC - 1)) ? WAY_W'(w) : age_pick_s;
        end
        victim_way = (|invalid_vec) ? inv_pick_s : age_pick_s;
    end

    // Age update: accessed way becomes youngest, younger ways than its old age shift up by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < ASSOC; w++) begin
                    age_r[s][w] <= WAY_W'(w);
                end
            end
        end else if (upd_en) begin
            for (int w = 0; w < ASSOC; w++) begin
                if (WAY_W'(w) == upd_way) begin
                    age_r[upd_set][w] <= '0;
                end else if (age_r[upd_set][w] < old_age_s) begin
                    age_r[upd_set][w] <= age_r[upd_set][w] + WAY_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/l3_cache_burst.sv
// Write-back, write-allocate set-associative L3 with multi-word lines and burst memory port.
module l3_cache_burst
    import l3_cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SETS   = 256,
    parameter int ASSOC      = 4,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
);

    localparam int OFFSET_BITS = calc_offset_bits(LINE_WORDS);
    localparam int OFF_W       = calc_field_width(OFFSET_BITS);
    localparam int SET_BITS    = calc_set_bits(NUM_SETS);
    localparam int TAG_W       = calc_tag_bits(ADDR_WIDTH, NUM_SETS, LINE_WORDS);
    localparam int WAY_W       = $clog2(ASSOC);

    line_meta_t            meta_r [NUM_SETS][ASSOC];
    logic [DATA_WIDTH-1:0] data_r [NUM_SETS][ASSOC][LINE_WORDS];

    state_t                state_r, state_s;
    logic                  ready_en_r;
    logic [TAG_W-1:0]      req_tag_r, vic_tag_r;
    logic [SET_BITS-1:0]   req_set_r;
    logic [OFF_W-1:0]      req_off_r, beat_r;
    logic                  req_wr_r;
    logic [DATA_WIDTH-1:0] req_wdata_r, rdata_r;
    logic [WAY_W-1:0]      vic_way_r;
    logic [31:0]           hit_cnt_r, miss_cnt_r;

    logic [ADDR_WIDTH-1:0] req_addr_s;
    logic [SET_BITS-1:0]   lk_set_s;
    logic [TAG_W-1:0]      lk_tag_s, line_tag_s;
    logic [OFF_W-1:0]      lk_off_s;
    logic [ASSOC-1:0]      hit_vec_s, invalid_vec_s;
    logic [WAY_W-1:0]      hit_way_s, victim_way_s, upd_way_s;
    logic [SET_BITS-1:0]   upd_set_s;
    logic                  hit_s, accept_rd_s, accept_wr_s, accept_s;
    logic                  victim_dirty_s, beat_done_s, last_beat_s, fill_last_s, upd_en_s;
    logic [DATA_WIDTH-1:0] fill_word_s;

    // Request decode and tag lookup for the request currently offered in IDLE.
    always_comb begin
        req_addr_s    = s_arvalid ? s_araddr : s_awaddr;
        lk_set_s      = SET_BITS'(req_addr_s >> OFFSET_BITS);
        lk_tag_s      = TAG_W'(req_addr_s >> (SET_BITS + OFFSET_BITS));
        lk_off_s      = OFF_W'(req_addr_s & ADDR_WIDTH'(LINE_WORDS - 1));
        hit_way_s     = '0;
        hit_vec_s     = '0;
        invalid_vec_s = '0;
        for (int w = 0; w < ASSOC; w++) begin
            hit_vec_s[w]     = meta_r[lk_set_s][w].valid && (meta_r[lk_set_s][w].tag[TAG_W-1:0] == lk_tag_s);
            invalid_vec_s[w] = !meta_r[lk_set_s][w].valid;
            hit_way_s        = hit_vec_s[w] ? WAY_W'(w) : hit_way_s;
        end
        hit_s          = |hit_vec_s;
        accept_rd_s    = (state_r == ST_IDLE) && ready_en_r && s_arvalid;
        accept_wr_s    = (state_r == ST_IDLE) && ready_en_r && !s_arvalid && s_awvalid && s_wvalid;
        accept_s       = accept_rd_s || accept_wr_s;
        victim_dirty_s = meta_r[lk_set_s][victim_way_s].valid && meta_r[lk_set_s][victim_way_s].dirty;
        beat_done_s    = mem_ready && ((state_r == ST_WB) || (state_r == ST_FILL));
        last_beat_s    = (beat_r == OFF_W'(LINE_WORDS - 1));
        fill_last_s    = beat_done_s && (state_r == ST_FILL) && last_beat_s;
        fill_word_s    = (req_wr_r && (beat_r == req_off_r)) ? req_wdata_r : mem_rdata;
        upd_en_s       = (accept_s && hit_s) || fill_last_s;
        upd_set_s      = (state_r == ST_IDLE) ? lk_set_s : req_set_r;
        upd_way_s      = (state_r == ST_IDLE) ? hit_way_s : vic_way_r;
        line_tag_s     = (state_r == ST_WB) ? vic_tag_r : req_tag_r;
    end

    l3_lru_ctrl #(
        .NUM_SETS (NUM_SETS),
        .ASSOC    (ASSOC)
    ) u_lru (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_set  (lk_set_s),
        .invalid_vec (invalid_vec_s),
        .victim_way  (victim_way_s),
        .upd_en      (upd_en_s),
        .upd_set     (upd_set_s),
        .upd_way     (upd_way_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (hit_s) begin
                        state_s = accept_rd_s ? ST_RESP_R : ST_RESP_B;
                    end else if (victim_dirty_s) begin
                        state_s = ST_WB;
                    end else begin
                        state_s = ST_FILL;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WB: begin
                if (beat_done_s && last_beat_s) begin
                    state_s = ST_FILL;
                end else begin
                    state_s = ST_WB;
                end
            end
            ST_FILL: begin
                if (fill_last_s) begin
                    state_s = req_wr_r ? ST_RESP_B : ST_RESP_R;
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_RESP_R: begin
                if (s_rready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP_R;
                end
            end
            ST_RESP_B: begin
                if (s_bready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP_B;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Request capture, beat counter, metadata, read-data latch and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_r  <= 1'b0;
            req_tag_r   <= '0;
            vic_tag_r   <= '0;
            req_set_r   <= '0;
            req_off_r   <= '0;
            beat_r      <= '0;
            req_wr_r    <= 1'b0;
            req_wdata_r <= '0;
            rdata_r     <= '0;
            vic_way_r   <= '0;
            hit_cnt_r   <= 32'd0;
            miss_cnt_r  <= 32'd0;
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < ASSOC; w++) begin
                    meta_r[s][w] <= '0;
                end
            end
        end else begin
            ready_en_r <= 1'b1;
            if (accept_s) begin
                req_tag_r   <= lk_tag_s;
                req_set_r   <= lk_set_s;
                req_off_r   <= lk_off_s;
                req_wr_r    <= accept_wr_s;
                req_wdata_r <= s_wdata;
                beat_r      <= '0;
                if (hit_s) begin
                    hit_cnt_r <= (hit_cnt_r == 32'hFFFF_FFFF) ? hit_cnt_r : hit_cnt_r + 32'd1;
                    if (accept_rd_s) begin
                        rdata_r <= data_r[lk_set_s][hit_way_s][lk_off_s];
                    end else begin
                        meta_r[lk_set_s][hit_way_s].dirty <= 1'b1;
                    end
                end else begin
                    miss_cnt_r <= (miss_cnt_r == 32'hFFFF_FFFF) ? miss_cnt_r : miss_cnt_r + 32'd1;
                    vic_way_r  <= victim_way_s;
                    vic_tag_r  <= meta_r[lk_set_s][victim_way_s].tag[TAG_W-1:0];
                end
            end
            if (beat_done_s) begin
                beat_r <= last_beat_s ? '0 : beat_r + OFF_W'(1);
                if ((state_r == ST_FILL) && !req_wr_r && (beat_r == req_off_r)) begin
                    rdata_r <= mem_rdata;
                end
            end
            if (fill_last_s) begin
                meta_r[req_set_r][vic_way_r] <= '{valid: 1'b1, dirty: req_wr_r, tag: TAG_MAX'(req_tag_r)};
            end
        end
    end

    // Line data storage: write hits and fill beats; contents are undefined until filled.
    always_ff @(posedge clk) begin
        if (accept_wr_s && hit_s) begin
            data_r[lk_set_s][hit_way_s][lk_off_s] <= s_wdata;
        end
        if (beat_done_s && (state_r == ST_FILL)) begin
            data_r[req_set_r][vic_way_r][beat_r] <= fill_word_s;
        end
    end

    assign s_arready = (state_r == ST_IDLE) && ready_en_r;
    assign s_awready = s_arready && !s_arvalid;
    assign s_wready  = s_arready && !s_arvalid;
    assign s_rvalid  = (state_r == ST_RESP_R);
    assign s_bvalid  = (state_r == ST_RESP_B);
    assign s_rdata   = rdata_r;
    assign mem_rd    = (state_r == ST_FILL);
    assign mem_wr    = (state_r == ST_WB);
    assign mem_addr  = (mem_rd || mem_wr)
                     ? ((ADDR_WIDTH'(line_tag_s) << (SET_BITS + OFFSET_BITS))
                        | (ADDR_WIDTH'(req_set_r) << OFFSET_BITS)
                        | ADDR_WIDTH'(beat_r))
                     : '0;
    assign mem_wdata = mem_wr ? data_r[req_set_r][vic_way_r][beat_r] : '0;
    assign hit_cnt   = hit_cnt_r;
    assign miss_cnt  = miss_cnt_r;

endmodule

// File: doc/l3_cache_burst.md
# l3_cache_burst

Parametrised unified L3 cache. Generalises the single-word L3 to multi-word lines, with burst fill and burst write-back on the downstream memory port. Replacement is true-age LRU, and hit/miss statistics counters are provided. Sits between the L2 (AXI-lite style single-beat slave, word-addressed) and the DRAM/RAM model (simple rd/wr/ready port). The policy is write-back, write-allocate.

## Interface
- ADDR_WIDTH, 32, word address width; one address = one DATA_WIDTH word
- DATA_WIDTH, 32, word width
- NUM_SETS, 256, sets; power of 2, ≥2
- ASSOC, 4, ways; power of 2, ≥2
- LINE_WORDS, 4, words per line; power of 2, ≥1. OFFSET_BITS = $clog2(LINE_WORDS), a zero-width field when LINE_WORDS=1.
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- s_araddr / s_arvalid / s_arready  in/in/out  ADDR_WIDTH/1/1  read address channel
- s_rdata / s_rvalid / s_rready  out/out/in  DATA_WIDTH/1/1  read data channel
- s_awaddr / s_awvalid / s_awready  in/in/out  ADDR_WIDTH/1/1  write address channel
- s_wdata / s_wvalid / s_wready  in/in/out  DATA_WIDTH/1/1  write data channel
- s_bvalid / s_bready  out/in  1/1  write response
- mem_addr  out  ADDR_WIDTH  beat word address
- mem_rd / mem_wr  out  1/1  read / write request, held until mem_ready
- mem_wdata  out  DATA_WIDTH  write-back beat data
- mem_rdata  in  DATA_WIDTH  fill beat data, valid with mem_ready
- mem_ready  in  1  beat complete
- hit_cnt / miss_cnt  out  32/32  saturating access counters

## Operation
- Address split: tag = addr[ADDR_WIDTH-1 : SET_BITS+OFFSET_BITS], set = next SET_BITS, offset = low OFFSET_BITS.
- States: IDLE, WB, FILL, RESP_R, RESP_B.
- Acceptance:
  - s_arready=1 in IDLE only.
  - s_awready = s_wready = IDLE && !s_arvalid. AW and W are accepted only in the same cycle, both valid.
  - Reads have priority over writes.
- Read hit: latch the word, update LRU, hit_cnt+1 → RESP_R.
- Write hit: write the word, set dirty, update LRU, hit_cnt+1 → RESP_B.
- Miss: miss_cnt+1; latch addr, wdata and kind. Victim is the lowest-index invalid way, else the way with age ASSOC-1.
  - Victim valid and dirty → WB, else → FILL.
- WB: LINE_WORDS beats at {victim_tag, set, beat}, beat 0..LINE_WORDS-1. mem_wr and mem_addr/mem_wdata are held until mem_ready, then advance. The last beat → FILL.
- FILL: LINE_WORDS mem_rd beats at {req_tag, set, beat}. Each mem_rdata is written on mem_ready.
  - Write miss: the beat whose index equals the request offset takes the saved wdata instead.
  - Last beat: valid=1, tag=req_tag, dirty = (write miss), LRU update → RESP_R (data = requested word) or RESP_B.
- RESP_R: s_rvalid=1, s_rdata stable until s_rready → IDLE.
- RESP_B: s_bvalid=1 until s_bready → IDLE.
- LRU: the accessed way's age → 0. Ways with age < the accessed way's old age get +1. Ages remain a permutation of 0..ASSOC-1.
- Counters saturate at 32'hFFFF_FFFF.

## Timing
- Reset values (asynchronous):
  - Outputs: all 0, counters 0, state IDLE.
  - Arrays: every line invalid and clean, age[s][w]=w.
  - Reset mid-burst aborts immediately; mem_rd/mem_wr drop, and dirty data is discarded by design.
- Hit: accepted in cycle N, s_rvalid/s_bvalid at N+1.
- Miss, clean victim: response at N+1+Σ(fill beat latencies)+1. A dirty victim adds the WB beats.
- mem_rd and mem_wr are never both high. At most one beat is outstanding. mem_ready is ignored when neither is asserted.
- Zero-wait memory (mem_ready tied 1): one beat per cycle.
- A held s_rvalid/s_bvalid with s_rready/s_bready low blocks all new acceptance.

## Structure
- Package l3_cache_pkg holds the state_t enum, the line metadata struct (valid, dirty, tag) and the address-split localparam functions.
- Sub-module l3_lru_ctrl owns the age arrays. It provides: the victim-select output (invalid-first input vector), the access-update port and reset init.
- Data array is NUM_SETS×ASSOC×LINE_WORDS words; the top module holds tags, data and the FSM.

## Test plan
Config for all scenarios: NUM_SETS=4, ASSOC=2, LINE_WORDS=4. Memory model: mem[a]=a^32'hA5A5_0000, mem_ready 2 cycles after request.
- Cold read 0x10 → 4 mem_rd beats at 0x10..0x13. s_rdata=0xA5A5_0010. miss_cnt=1. A re-read of 0x12 hits at N+1 with 0xA5A5_0012 and hit_cnt=1.
- Write miss 0x21, wdata 0xDEAD_BEEF → fill 0x20..0x23. s_bvalid asserted. A read of 0x21 returns 0xDEAD_BEEF; a read of 0x22 returns 0xA5A5_0022.
- Fill set 0 with tags for 0x00 and 0x10, dirtying 0x00 by a write of 0x1111_1111 to 0x03. Touch 0x10, then read 0x20 → victim way(0x00) is written back:
  - Beats 0x00..0x03, with beat 3 = 0x1111_1111.
  - Then a fill of 0x20..0x23.
- Assert s_arvalid and s_awvalid+s_wvalid in the same cycle → read accepted first, write accepted only on return to IDLE; both responses are correct.
- Hold s_rready=0 for 5 cycles → s_rvalid/s_rdata stable, s_arready=0 throughout.
- Assert rst_n=0 during FILL beat 2 → mem_rd=0 immediately, all outputs 0. A subsequent read of the same address misses again.
